// File: rtl/dmem_arb_if.sv
// rtl/dmem_arb_if.sv - core and host request/response bundle for the dmem arbiter
interface dmem_arb_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          c_req;
    logic          c_we;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;
    logic          c_gnt;
    logic          c_rvalid;
    logic [DW-1:0] c_rdata;
    logic          core_stall;

    logic          h_req;
    logic          h_we;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_wdata;
    logic          h_lock;
    logic          h_gnt;
    logic          h_rvalid;
    logic [DW-1:0] h_rdata;

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_gnt, c_rvalid, c_rdata, core_stall,
        output h_req, h_we, h_addr, h_wdata, h_lock,
        input  h_gnt, h_rvalid, h_rdata
    );

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_gnt, c_rvalid, c_rdata, core_stall,
        input  h_req, h_we, h_addr, h_wdata, h_lock,
        output h_gnt, h_rvalid, h_rdata
    );
endinterface

// File: rtl/dmem_arb.sv
// rtl/dmem_arb.sv - round-robin core/host arbiter for the single dmem port
// Grants are combinational; load data returns one cycle after the grant.
module dmem_arb #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int LOCK_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arb_if.slave     bus,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_di,
    input  logic [DW-1:0] m_dout
);
    localparam int CW = $clog2(LOCK_MAX + 1);

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_HOST = 1'b1
    } owner_e;

    owner_e        last_owner_q, last_owner_d;
    logic [CW-1:0] lock_cnt_q, lock_cnt_d;
    logic          c_rvalid_q, h_rvalid_q;
    logic [DW-1:0] c_rdata_q, h_rdata_q;
    logic          c_win, h_win, host_locked;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_owner_q <= OWN_HOST;
            lock_cnt_q   <= '0;
        end else begin
            last_owner_q <= last_owner_d;
            lock_cnt_q   <= lock_cnt_d;
        end
    end

    always_comb begin
        c_win        = 1'b0;
        h_win        = 1'b0;
        last_owner_d = last_owner_q;
        lock_cnt_d   = lock_cnt_q;
        host_locked  = (last_owner_q == OWN_HOST) && bus.h_lock &&
                       (lock_cnt_q < CW'(LOCK_MAX));

        // No grants while reset is held so nothing reaches memory.
        if (!reset) begin
            if (bus.c_req && bus.h_req) begin
                if (host_locked)                    h_win = 1'b1;
                else if (last_owner_q == OWN_HOST)  c_win = 1'b1;
                else                                h_win = 1'b1;
            end else begin
                c_win = bus.c_req;
                h_win = bus.h_req;
            end
        end

        if (c_win)      last_owner_d = OWN_CORE;
        else if (h_win) last_owner_d = OWN_HOST;

        // The lock budget only counts host beats that actually made the core wait.
        if (c_win || !bus.h_lock)
            lock_cnt_d = '0;
        else if (h_win && bus.c_req && (lock_cnt_q != CW'(LOCK_MAX)))
            lock_cnt_d = lock_cnt_q + 1'b1;
    end

    always_comb begin
        m_we   = c_win ? bus.c_we : (h_win & bus.h_we);
        m_addr = h_win ? bus.h_addr  : bus.c_addr;
        m_di   = h_win ? bus.h_wdata : bus.c_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_rvalid_q <= 1'b0;
            h_rvalid_q <= 1'b0;
            c_rdata_q  <= '0;
            h_rdata_q  <= '0;
        end else begin
            c_rvalid_q <= c_win & ~bus.c_we;
            h_rvalid_q <= h_win & ~bus.h_we;
            if (c_win && !bus.c_we) c_rdata_q <= m_dout;
            if (h_win && !bus.h_we) h_rdata_q <= m_dout;
        end
    end

    assign bus.c_gnt      = c_win;
    assign bus.h_gnt      = h_win;
    assign bus.core_stall = bus.c_req & ~c_win;
    assign bus.c_rvalid   = c_rvalid_q;
    assign bus.h_rvalid   = h_rvalid_q;
    assign bus.c_rdata    = c_rdata_q;
    assign bus.h_rdata    = h_rdata_q;
endmodule

// File: tb/tb_dmem_arb.sv
// tb/tb_dmem_arb.sv - scoreboard bench for dmem_arb with a behavioural arbitration model
module tb_dmem_arb;
    localparam int AW = 8, DW = 8, LOCK_MAX = 4;

    logic clk = 1'b0;
    logic rst;
    logic mem_clr;
    always #5 clk = ~clk;

    dmem_arb_if #(.AW(AW), .DW(DW)) bus ();
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_di, m_dout;

    dmem_arb #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .reset(rst), .bus(bus),
        .m_we(m_we), .m_addr(m_addr), .m_di(m_di), .m_dout(m_dout)
    );

    // dmem: combinational read, write at the clock edge
    logic [DW-1:0] mem [256];
    assign m_dout = mem[m_addr];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (m_we) begin
            mem[m_addr] <= m_di;
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct { int due; logic [DW-1:0] data; } rd_t;
    rd_t cq[$];
    rd_t hq[$];
    int  glog[$];
    logic c_gnt_s = 1'b0, h_gnt_s = 1'b0;

    // reference model: who should win, what memory holds, which reads are owed
    int            mdl_last;
    int            mdl_cnt;
    logic [DW-1:0] ref_mem [256];

    always @(negedge clk) begin : model
        int            win;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        c_gnt_s = bus.c_gnt;
        h_gnt_s = bus.h_gnt;
        glog.push_back(bus.c_gnt ? 1 : (bus.h_gnt ? 2 : 0));
        if (mem_clr) for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        if (rst) begin
            chk("rst_c_gnt", bus.c_gnt, 0);
            chk("rst_h_gnt", bus.h_gnt, 0);
            chk("rst_m_we", m_we, 0);
            chk("rst_core_stall", bus.core_stall, bus.c_req);
            mdl_last = 1;
            mdl_cnt  = 0;
        end else begin
            if (bus.c_req && bus.h_req) begin
                if (mdl_last == 1 && bus.h_lock && mdl_cnt < LOCK_MAX) win = 2;
                else win = (mdl_last == 1) ? 1 : 2;
            end else begin
                win = bus.c_req ? 1 : (bus.h_req ? 2 : 0);
            end
            chk("c_gnt", bus.c_gnt, (win == 1));
            chk("h_gnt", bus.h_gnt, (win == 2));
            chk("core_stall", bus.core_stall, (bus.c_req && win != 1));
            if (win == 0) begin
                chk("idle_m_we", m_we, 0);
                chk("idle_m_addr", m_addr, bus.c_addr);
            end else begin
                we   = (win == 1) ? bus.c_we    : bus.h_we;
                addr = (win == 1) ? bus.c_addr  : bus.h_addr;
                wd   = (win == 1) ? bus.c_wdata : bus.h_wdata;
                chk("m_we", m_we, we);
                chk("m_addr", m_addr, addr);
                if (we) begin
                    chk("m_di", m_di, wd);
                    ref_mem[addr] = wd;
                end else if (win == 1) begin
                    cq.push_back('{due: cyc + 1, data: ref_mem[addr]});
                end else begin
                    hq.push_back('{due: cyc + 1, data: ref_mem[addr]});
                end
                mdl_last = (win == 1) ? 0 : 1;
            end
            if (win == 1 || !bus.h_lock) mdl_cnt = 0;
            else if (win == 2 && bus.c_req) mdl_cnt++;
        end
    end

    // monitor: pops owed read data whenever a return port shows valid
    logic [DW-1:0] c_last = '0, h_last = '0;
    always @(negedge clk) begin : monitor
        rd_t e;
        if (rst) begin
            chk("rst_c_rvalid", bus.c_rvalid, 0);
            chk("rst_h_rvalid", bus.h_rvalid, 0);
            chk("rst_c_rdata", bus.c_rdata, 0);
            chk("rst_h_rdata", bus.h_rdata, 0);
            cq.delete();
            hq.delete();
            c_last = '0;
            h_last = '0;
        end else begin
            if (bus.c_rvalid) begin
                if (cq.size() == 0 || cq[0].due != cyc) chk("c_rvalid_unexpected", bus.c_rvalid, 0);
                else begin
                    e = cq.pop_front();
                    chk("c_rdata", bus.c_rdata, e.data);
                    c_last = e.data;
                end
            end else begin
                if (cq.size() > 0 && cq[0].due == cyc) begin
                    chk("c_rvalid_missing", bus.c_rvalid, 1);
                    void'(cq.pop_front());
                end
                chk("c_rdata_hold", bus.c_rdata, c_last);
            end
            if (bus.h_rvalid) begin
                if (hq.size() == 0 || hq[0].due != cyc) chk("h_rvalid_unexpected", bus.h_rvalid, 0);
                else begin
                    e = hq.pop_front();
                    chk("h_rdata", bus.h_rdata, e.data);
                    h_last = e.data;
                end
            end else begin
                if (hq.size() > 0 && hq[0].due == cyc) begin
                    chk("h_rvalid_missing", bus.h_rvalid, 1);
                    void'(hq.pop_front());
                end
                chk("h_rdata_hold", bus.h_rdata, h_last);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.c_req = 0; bus.c_we = 0; bus.c_addr = '0; bus.c_wdata = '0;
        bus.h_req = 0; bus.h_we = 0; bus.h_addr = '0; bus.h_wdata = '0;
        bus.h_lock = 0;
    endtask

    task automatic expect_pat(input string nm, input int pat[$]);
        chk({nm, "_len"}, glog.size(), pat.size());
        for (int i = 0; i < pat.size() && i < glog.size(); i++) chk(nm, glog[i], pat[i]);
    endtask

    initial begin
        logic cp, hp;
        rst = 1; mem_clr = 1;
        idle();
        repeat (3) step();
        mem_clr = 0; rst = 0;
        step();

        // core store then load of 0x10
        bus.c_req = 1; bus.c_we = 1; bus.c_addr = 8'h10; bus.c_wdata = 8'h5A;
        glog.delete();
        step();
        bus.c_we = 0;
        step();
        expect_pat("core_only", '{1, 1});
        idle();
        @(negedge clk);
        chk("t1_c_rvalid", bus.c_rvalid, 1);
        chk("t1_c_rdata", bus.c_rdata, 8'h5A);
        step();

        // host write 0xFF then core load the next cycle
        bus.h_req = 1; bus.h_we = 1; bus.h_addr = 8'hFF; bus.h_wdata = 8'h33;
        step();
        idle();
        bus.c_req = 1; bus.c_addr = 8'hFF;
        step();
        idle();
        @(negedge clk);
        chk("t4_c_rdata", bus.c_rdata, 8'h33);
        step();

        // both requesting, no lock: strict alternation
        bus.h_req = 1; bus.h_addr = 8'h20;
        glog.delete();
        step();
        bus.c_req = 1; bus.c_addr = 8'h21;
        repeat (6) step();
        expect_pat("alternate", '{2, 1, 2, 1, 2, 1, 2});

        // host lock: LOCK_MAX host beats then one core beat
        bus.h_lock = 1;
        glog.delete();
        repeat (10) step();
        expect_pat("lock", '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1});

        // idle for ten cycles
        idle();
        glog.delete();
        repeat (10) step();
        expect_pat("idle", '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0});

        // reset right after a granted host load
        bus.h_req = 1; bus.h_addr = 8'hFF;
        step();
        rst = 1; idle();
        bus.c_req = 1; bus.c_addr = 8'h10;
        @(negedge clk);
        chk("t6_h_rvalid", bus.h_rvalid, 0);
        chk("t6_c_gnt", bus.c_gnt, 0);
        chk("t6_core_stall", bus.core_stall, 1);
        step();
        rst = 0;
        bus.h_req = 1; bus.h_addr = 8'h10;
        glog.delete();
        step();
        expect_pat("post_rst_tie", '{1});
        idle();
        step();

        // randomized traffic with hold-until-grant requesters
        cp = 0; hp = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!cp || c_gnt_s) begin
                cp = ($urandom_range(0, 9) < 7);
                bus.c_we    = $urandom_range(0, 1) == 1;
                bus.c_addr  = AW'($urandom_range(0, 15));
                bus.c_wdata = DW'($urandom);
            end
            if (!hp || h_gnt_s) begin
                hp = ($urandom_range(0, 9) < 6);
                bus.h_we    = $urandom_range(0, 1) == 1;
                bus.h_addr  = AW'($urandom_range(0, 15));
                bus.h_wdata = DW'($urandom);
            end
            bus.c_req  = cp;
            bus.h_req  = hp;
            bus.h_lock = ($urandom_range(0, 99) < 60);
            rst        = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 0;
        idle();
        repeat (3) step();
        chk("cq_drained", cq.size(), 0);
        chk("hq_drained", hq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
